rom_fetch_unit: RTL and testbench

//  Sequential reader for the 4096x8 combinational program ROM. Owns the program

---
 rtl/rom_fetch_unit.sv | 127 ++++++++++++
 tb/tb_rom_fetch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_unit
// Purpose  : Sequential reader for a combinational program ROM. It owns the
//            program counter and drives the ROM address from it. Each byte the
//            ROM returns is captured into an output register and offered
//            downstream over a valid/ready handshake. Jump (load) and run/stop
//            (en) control are supported.
// Ports    : clk          - single clock, all state on rising edge
//            reset        - synchronous, active-high
//            en           - 1 = fetch sequentially, 0 = stop fetching
//            load         - jump: pc <= load_addr, pending byte flushed
//            load_addr    - jump target
//            rom_addr     - ROM address (registered program counter)
//            rom_data     - ROM data, combinational from rom_addr
//            instr        - fetched byte
//            instr_addr   - address instr was read from
//            instr_valid  - instr/instr_addr hold a byte not yet accepted
//            instr_ready  - downstream accepts when valid && ready
//            wrap         - one-cycle pulse when pc advances all-ones -> 0
// Revision : 1.0 - initial release
// ============================================================================
module rom_fetch_unit #(
    parameter int ADDR_W                  = 12,
    parameter int DATA_W                  = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              wrap
);

    // State encoding
    localparam logic [1:0] c_st_idle  = 2'd0;  // not fetching
    localparam logic [1:0] c_st_run   = 2'd1;  // capturing
    localparam logic [1:0] c_st_stall = 2'd2;  // byte pending, not accepted

    localparam logic [ADDR_W-1:0] c_pc_max = '1;
    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_addr;
    logic              r_valid;
    logic              r_wrap;
    logic [1:0]        r_state;

    logic              w_capture;
    logic              w_stall;
    logic [1:0]        w_state_nxt;

    // A new byte may be taken when the output register is empty or is being
    // drained on this same edge; load has priority and suppresses capture.
    assign w_capture = en && !load && (!r_valid || instr_ready);
    assign w_stall   = r_valid && !instr_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = en ? c_st_run : c_st_idle;
        end else begin
            case (r_state)
                // A stalled byte is always valid, so leaving only needs ready.
                c_st_stall: begin
                    if (instr_ready) begin
                        w_state_nxt = en ? c_st_run : c_st_idle;
                    end
                end
                default: begin
                    if (w_stall) begin
                        w_state_nxt = c_st_stall;
                    end else begin
                        w_state_nxt = en ? c_st_run : c_st_idle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_ADDR;
            r_instr      <= '0;
            r_instr_addr <= '0;
            r_valid      <= 1'b0;
            r_wrap       <= 1'b0;
            r_state      <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
            if (load) begin
                // Jump: any pending byte is discarded even if ready is high.
                r_pc    <= load_addr;
                r_valid <= 1'b0;
                r_wrap  <= 1'b0;
            end else if (w_capture) begin
                r_instr      <= rom_data;
                r_instr_addr <= r_pc;
                r_valid      <= 1'b1;
                r_pc         <= r_pc + c_pc_one;
                r_wrap       <= (r_pc == c_pc_max);
            end else begin
                r_wrap <= 1'b0;
                // Stopped but downstream took the pending byte.
                if (r_valid && instr_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign rom_addr    = r_pc;
    assign instr       = r_instr;
    assign instr_addr  = r_instr_addr;
    assign instr_valid = r_valid;
    assign wrap        = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch_unit
// Purpose  : Directed self-checking bench for rom_fetch_unit, with a
//            combinational ROM model ROM[a] = a[7:0] ^ 8'h5A.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic        load;
    logic [11:0] load_addr;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  instr;
    logic [11:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    rom_fetch_unit #(
        .ADDR_W    (12),
        .DATA_W    (8),
        .RESET_ADDR(12'h000)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .load_addr  (load_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .wrap       (wrap)
    );

    assign rom_data = rom_addr[7:0] ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_instr, input logic [11:0] e_iaddr,
                           input logic e_valid, input logic e_wrap, input logic [11:0] e_rom);
        chk({tag, ".instr"}, 32'(instr), 32'(e_instr));
        chk({tag, ".instr_addr"}, 32'(instr_addr), 32'(e_iaddr));
        chk({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
        chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(e_rom));
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; load = 1'b0; load_addr = 12'h000; instr_ready = 1'b1;

        // 1: reset then sequential fetch at full rate
        step();
        chk_out("t1_reset", 8'h00, 12'h000, 1'b0, 1'b0, 12'h000);
        reset = 1'b0;
        step(); chk_out("t1_e1", 8'h5A, 12'h000, 1'b1, 1'b0, 12'h001);
        step(); chk_out("t1_e2", 8'h5B, 12'h001, 1'b1, 1'b0, 12'h002);
        step(); chk_out("t1_e3", 8'h58, 12'h002, 1'b1, 1'b0, 12'h003);

        // 2: backpressure after first capture
        reset = 1'b1; step(); reset = 1'b0;
        step(); chk_out("t2_first", 8'h5A, 12'h000, 1'b1, 1'b0, 12'h001);
        instr_ready = 1'b0;
        step(); chk_out("t2_hold1", 8'h5A, 12'h000, 1'b1, 1'b0, 12'h001);
        step(); chk_out("t2_hold2", 8'h5A, 12'h000, 1'b1, 1'b0, 12'h001);
        step(); chk_out("t2_hold3", 8'h5A, 12'h000, 1'b1, 1'b0, 12'h001);
        instr_ready = 1'b1;
        step(); chk_out("t2_resume", 8'h5B, 12'h001, 1'b1, 1'b0, 12'h002);

        // 3: load with a pending byte and ready low flushes it
        instr_ready = 1'b0; load = 1'b1; load_addr = 12'h7F0;
        step(); chk_out("t3_load", 8'h5B, 12'h001, 1'b0, 1'b0, 12'h7F0);
        load = 1'b0; instr_ready = 1'b1;
        step(); chk_out("t3_fetch", 8'hAA, 12'h7F0, 1'b1, 1'b0, 12'h7F1);

        // 4: wrap around the top of the address space
        load = 1'b1; load_addr = 12'hFFE;
        step(); chk_out("t4_load", 8'hAA, 12'h7F0, 1'b0, 1'b0, 12'hFFE);
        load = 1'b0;
        step(); chk_out("t4_ffe", 8'hA4, 12'hFFE, 1'b1, 1'b0, 12'hFFF);
        step(); chk_out("t4_fff", 8'hA5, 12'hFFF, 1'b1, 1'b1, 12'h000);
        step(); chk_out("t4_000", 8'h5A, 12'h000, 1'b1, 1'b0, 12'h001);

        // 5: stop with byte pending and ready high, then resume at same pc
        en = 1'b0;
        step(); chk_out("t5_drop", 8'h5A, 12'h000, 1'b0, 1'b0, 12'h001);
        step(); chk_out("t5_idle", 8'h5A, 12'h000, 1'b0, 1'b0, 12'h001);
        en = 1'b1;
        step(); chk_out("t5_resume", 8'h5B, 12'h001, 1'b1, 1'b0, 12'h002);

        // 5b: stopped with ready low keeps the pending byte
        en = 1'b0; instr_ready = 1'b0;
        step(); chk_out("t5_keep", 8'h5B, 12'h001, 1'b1, 1'b0, 12'h002);
        en = 1'b1;

        // 6: reset during stall
        step(); chk_out("t6_stall", 8'h5B, 12'h001, 1'b1, 1'b0, 12'h002);
        reset = 1'b1;
        step(); chk_out("t6_reset", 8'h00, 12'h000, 1'b0, 1'b0, 12'h000);
        reset = 1'b0; instr_ready = 1'b1;

        // 7: load to the current pc acts as flush and refetch
        step(); chk_out("t7_first", 8'h5A, 12'h000, 1'b1, 1'b0, 12'h001);
        load = 1'b1; load_addr = 12'h001;
        step(); chk_out("t7_flush", 8'h5A, 12'h000, 1'b0, 1'b0, 12'h001);
        load = 1'b0;
        step(); chk_out("t7_refetch", 8'h5B, 12'h001, 1'b1, 1'b0, 12'h002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
